// File: rtl/audio_sample_reader.sv
// Paced audio sample reader: pops one FIFO entry per sample period, holds it as
// the current sample and renders it through a free-running PWM.
//
// state   | meaning
// IDLE    | waiting for the sample-period tick
// READ    | fifo_rd pulse active, FIFO presents data next cycle
// CAPTURE | FIFO data valid, latched into sample at the closing edge
module audio_sample_reader #(
  parameter int DBITS = 8,
  parameter int DIV   = 2267
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [DBITS-1:0] fifo_dout,
  output logic             fifo_rd,
  input  logic             underrun_clr,
  output logic [DBITS-1:0] sample,
  output logic             sample_valid,
  output logic             underrun,
  output logic             pwm_out
);

  localparam logic [15:0]      DIV_M1   = 16'(DIV - 1);
  localparam logic [DBITS-1:0] MIDSCALE = {1'b1, {(DBITS-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      tick_cnt_q, tick_cnt_d;
  logic [DBITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DBITS-1:0] sample_q, sample_d;
  logic             fifo_rd_q, fifo_rd_d;
  logic             sample_valid_q, sample_valid_d;
  logic             underrun_q, underrun_d;
  logic             pwm_out_q, pwm_out_d;
  logic             tick;

  assign tick = enable && (tick_cnt_q == DIV_M1);

  always_comb begin
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    pwm_cnt_d      = pwm_cnt_q + 1'b1;
    sample_d       = sample_q;
    fifo_rd_d      = 1'b0;
    sample_valid_d = 1'b0;
    // a set in the same cycle as a clear wins below
    underrun_d     = underrun_q & ~underrun_clr;
    pwm_out_d      = (pwm_cnt_q < sample_q);

    if (!enable) begin
      tick_cnt_d = 16'd0;
    end else if (tick) begin
      tick_cnt_d = 16'd0;
    end else begin
      tick_cnt_d = tick_cnt_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          if (fifo_empty) begin
            underrun_d     = 1'b1;
            sample_d       = MIDSCALE;
            sample_valid_d = 1'b1;
          end else begin
            state_d   = READ;
            fifo_rd_d = 1'b1;
          end
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        sample_d       = fifo_dout;
        sample_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      tick_cnt_q     <= 16'd0;
      pwm_cnt_q      <= '0;
      sample_q       <= MIDSCALE;
      fifo_rd_q      <= 1'b0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
      pwm_out_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      sample_q       <= sample_d;
      fifo_rd_q      <= fifo_rd_d;
      sample_valid_q <= sample_valid_d;
      underrun_q     <= underrun_d;
      pwm_out_q      <= pwm_out_d;
    end
  end

  assign fifo_rd      = fifo_rd_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign underrun     = underrun_q;
  assign pwm_out      = pwm_out_q;

endmodule

// File: doc/audio_sample_reader.md
AUDIO_SAMPLE_READER -- requirements
Module: audio_sample_reader

Interface
REQ-001 Parameter DBITS, default 8, sample width in bits.
REQ-002 Parameter DIV, default 2267, system clocks per sample period; legal range 4..65535.
REQ-003 clock  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; reset reset, asynchronous, active-high; clock clock.
REQ-005 enable  input  1  playback enable, level.
REQ-006 fifo_empty  input  1  empty flag from sample FIFO.
REQ-007 fifo_dout  input  DBITS  FIFO read data, valid the cycle after fifo_rd.
REQ-008 fifo_rd  output  1  FIFO pop strobe, one-cycle pulse.
REQ-009 underrun_clr  input  1  clears underrun flag.
REQ-010 sample  output  DBITS  currently playing sample, unsigned, midscale = silence.
REQ-011 sample_valid  output  1  one-cycle pulse when sample is updated.
REQ-012 underrun  output  1  sticky flag: sample tick found FIFO empty.
REQ-013 pwm_out  output  1  PWM audio output.

Function
REQ-014 Tick counter, 16 bit, SHALL count 0..DIV-1 while enable=1, wrap to 0; tick asserted when count==DIV-1 and enable=1.
REQ-015 enable=0 SHALL hold the tick counter at 0 and suppress ticks; an in-flight read SHALL still complete.
REQ-016 FSM states SHALL be IDLE, READ, CAPTURE; all outputs registered.
REQ-017 IDLE: tick and fifo_empty=0 -> READ; tick and fifo_empty=1 -> stay IDLE, set underrun, load sample with midscale 2^(DBITS-1), pulse sample_valid next cycle.
REQ-018 READ: fifo_rd=1 for exactly this cycle -> CAPTURE unconditionally.
REQ-019 CAPTURE: on the edge ending CAPTURE, sample <= fifo_dout, sample_valid=1 for the following cycle only -> IDLE.
REQ-020 Latency: tick edge to sample update SHALL be exactly 3 clock edges; fifo_rd SHALL never assert outside READ.
REQ-021 fifo_rd SHALL assert at most once per sample period; DIV>=4 guarantees FSM is IDLE at every tick.
REQ-022 fifo_empty SHALL be sampled only in IDLE at tick; its changes during READ/CAPTURE SHALL be ignored.
REQ-023 underrun SHALL remain 1 until underrun_clr=1; simultaneous set and clear SHALL leave underrun=1.
REQ-024 PWM counter, DBITS wide, SHALL free-run 0..2^DBITS-1 and wrap, independent of enable.
REQ-025 pwm_out SHALL be registered (pwm_cnt < sample); sample=0 gives constant 0, sample=2^DBITS-1 gives high 2^DBITS-1 of every 2^DBITS cycles.
REQ-026 A sample change SHALL take effect on the next PWM compare without waiting for PWM wrap.

Reset
REQ-027 On reset: state IDLE, tick counter 0, pwm counter 0, fifo_rd 0, sample 2^(DBITS-1), sample_valid 0, underrun 0, pwm_out 0.
REQ-028 Reset asserted mid-READ or mid-CAPTURE SHALL abort the read with no sample_valid; the popped FIFO entry is discarded.
REQ-029 After reset release, first tick SHALL occur DIV cycles after enable is first sampled high.

Verification
REQ-030 DIV=8, DBITS=8, enable=1, FIFO holds 0x10,0x20 -> fifo_rd pulses every 8 cycles; sample=0x10 then 0x20, each 3 edges after tick, sample_valid one cycle each.
REQ-031 FIFO empty at tick -> no fifo_rd, sample=0x80, sample_valid pulse, underrun=1; underrun_clr=1 with no further underrun -> underrun=0 next cycle.
REQ-032 underrun_clr=1 in the same cycle as a new underrun -> underrun stays 1.
REQ-033 sample=0x40 steady -> pwm_out high exactly 64 of every 256 cycles; sample=0x00 -> pwm_out never high.
REQ-034 enable dropped in READ -> CAPTURE completes, sample updated once, then no fifo_rd while enable=0; re-enable -> first tick after 8 cycles.
REQ-035 reset pulsed during CAPTURE -> sample=0x80, sample_valid never asserts, state IDLE, tick counter 0.
